// File: rtl/proc_ctrl_fsm_if.sv
// rtl/proc_ctrl_fsm_if.sv - control bundle between the processor sequencer and its datapath/caller
interface proc_ctrl_fsm_if #(
  parameter int DIN_W = 16
) ();
  logic             run;
  logic [DIN_W-1:0] din;
  logic             gnz;
  logic             irin;
  logic [7:0]       rin;
  logic [7:0]       rout;
  logic             ain;
  logic             gin;
  logic             gout;
  logic             dinout;
  logic             addsub;
  logic             done;
  logic             busy;
  logic [1:0]       tstep;

  modport slave (
    input  run, din, gnz,
    output irin, rin, rout, ain, gin, gout, dinout, addsub, done, busy, tstep
  );

  modport master (
    output run, din, gnz,
    input  irin, rin, rout, ain, gin, gout, dinout, addsub, done, busy, tstep
  );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// rtl/proc_ctrl_fsm.sv - T0..T3 control sequencer for the 8-register basic processor
// Optional mvnz instruction (opcode 100) is compiled in with PROC_CTRL_MVNZ_EN.
module proc_ctrl_fsm #(
  parameter int DIN_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  proc_ctrl_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  tstep_e           state, state_nxt;
  logic [8:0]       ir;
  logic [DIN_W-1:0] din_w;
  logic [2:0]       opcode, rx, ry;
  logic             unused_bits;

  logic             irin, ain, gin, gout, dinout, addsub, done;
  logic [7:0]       rin, rout;

  // Only DIN[8:0] is an instruction; Gnz is meaningful only with mvnz compiled in.
  assign din_w       = bus.din;
  assign unused_bits = ^{din_w, bus.gnz};

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  function automatic logic [7:0] onehot(input logic [2:0] sel);
    onehot = 8'd1 << sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && bus.run) begin
        ir <= din_w[8:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    irin      = 1'b0;
    rin       = 8'h00;
    rout      = 8'h00;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    dinout    = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    case (state)
      T0: begin
        irin = bus.run;
        if (bus.run) begin
          state_nxt = T1;
        end
      end
      T1: begin
        state_nxt = T0;
        case (opcode)
          OP_MV: begin
            rout = onehot(ry);
            rin  = onehot(rx);
            done = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin    = onehot(rx);
            done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout      = onehot(rx);
            ain       = 1'b1;
            state_nxt = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            done = 1'b1;
            if (bus.gnz) begin
              rout = onehot(ry);
              rin  = onehot(rx);
            end
          end
`endif
          // Illegal opcodes retire as a single-cycle NOP.
          default: done = 1'b1;
        endcase
      end
      T2: begin
        rout      = onehot(ry);
        gin       = 1'b1;
        addsub    = (opcode == OP_SUB);
        state_nxt = T3;
      end
      T3: begin
        gout      = 1'b1;
        rin       = onehot(rx);
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  assign bus.irin   = irin;
  assign bus.rin    = rin;
  assign bus.rout   = rout;
  assign bus.ain    = ain;
  assign bus.gin    = gin;
  assign bus.gout   = gout;
  assign bus.dinout = dinout;
  assign bus.addsub = addsub;
  assign bus.done   = done;
  assign bus.busy   = (state != T0);
  assign bus.tstep  = state;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb/tb_proc_ctrl_fsm.sv - self-checking bench for proc_ctrl_fsm (directed plan + randomized run)
module tb_proc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  proc_ctrl_fsm_if #(.DIN_W(16)) bus ();

  proc_ctrl_fsm #(.DIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef PROC_CTRL_MVNZ_EN
  localparam bit MVNZ = 1'b1;
`else
  localparam bit MVNZ = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] tstep;
    logic       busy;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;
  } outs_t;

  typedef struct {
    logic [8:0] ir;
    int         step;
  } ent_t;

  ent_t q[$];
  int   ntot  = 0;
  int   npass = 0;

  // Expected outputs for an instruction at a given step (0 = waiting for fetch).
  function automatic outs_t expect_outs(input logic [8:0] ir, input int step,
                                        input logic g, input logic r);
    outs_t e;
    int op, x, y;
    e       = '0;
    op      = int'(ir[8:6]);
    x       = int'(ir[5:3]);
    y       = int'(ir[2:0]);
    e.tstep = 2'(step);
    e.busy  = (step != 0);
    if (step == 0) begin
      e.irin = r;
    end else if (op == 2 || op == 3) begin
      if (step == 1) begin
        e.rout = 8'(1 << x);
        e.ain  = 1'b1;
      end else if (step == 2) begin
        e.rout   = 8'(1 << y);
        e.gin    = 1'b1;
        e.addsub = (op == 3);
      end else begin
        e.gout = 1'b1;
        e.rin  = 8'(1 << x);
        e.done = 1'b1;
      end
    end else begin
      e.done = 1'b1;
      if (op == 0 || (MVNZ && op == 4 && g)) begin
        e.rout = 8'(1 << y);
        e.rin  = 8'(1 << x);
      end else if (op == 1) begin
        e.dinout = 1'b1;
        e.rin    = 8'(1 << x);
      end
    end
    return e;
  endfunction

  function automatic outs_t actual_outs();
    outs_t a;
    a.tstep  = bus.tstep;
    a.busy   = bus.busy;
    a.irin   = bus.irin;
    a.rin    = bus.rin;
    a.rout   = bus.rout;
    a.ain    = bus.ain;
    a.gin    = bus.gin;
    a.gout   = bus.gout;
    a.dinout = bus.dinout;
    a.addsub = bus.addsub;
    a.done   = bus.done;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    if (got === want) npass++;
    else $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
  endtask

  // Reference model: a queue of pending instruction steps.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (bus.run) begin
      int n;
      n = (bus.din[8:6] == 3'd2 || bus.din[8:6] == 3'd3) ? 3 : 1;
      for (int s = 1; s <= n; s++) q.push_back('{bus.din[8:0], s});
    end
  end

  always @(negedge clk) begin
    outs_t want;
    if (!rst_n || q.size() == 0) want = expect_outs(9'd0, 0, bus.gnz, bus.run);
    else                         want = expect_outs(q[0].ir, q[0].step, bus.gnz, bus.run);
    chk("cycle", 32'(actual_outs()), 32'(want));
  end

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.run = 1'b1;
    bus.din = 16'h0015;
    bus.gnz = 1'b0;
    #2;
    chk("rst_irin", 32'(bus.irin), 32'd1);
    chk("rst_tstep", 32'(bus.tstep), 32'd0);
    edge_drive();
    rst_n = 1'b1;

    // mv R2,R5
    @(negedge clk); chk("mv_t0_irin", 32'(bus.irin), 32'd1);
    edge_drive();   bus.run = 1'b0;
    @(negedge clk);
    chk("mv_t1_tstep", 32'(bus.tstep), 32'd1);
    chk("mv_t1_rout", 32'(bus.rout), 32'h20);
    chk("mv_t1_rin", 32'(bus.rin), 32'h04);
    chk("mv_t1_done", 32'(bus.done), 32'd1);
    edge_drive();
    @(negedge clk); chk("mv_after_tstep", 32'(bus.tstep), 32'd0);

    // mvi R1
    edge_drive();   bus.din = 16'h0048; bus.run = 1'b1;
    edge_drive();   bus.run = 1'b0;
    @(negedge clk);
    chk("mvi_dinout", 32'(bus.dinout), 32'd1);
    chk("mvi_rin", 32'(bus.rin), 32'h02);
    chk("mvi_rout", 32'(bus.rout), 32'h00);
    chk("mvi_done", 32'(bus.done), 32'd1);

    // add R3,R6 followed back-to-back by sub R0,R7
    edge_drive();   bus.din = 16'h009E; bus.run = 1'b1;
    edge_drive();   bus.din = 16'h00C7;
    @(negedge clk);
    chk("add_t1_rout", 32'(bus.rout), 32'h08);
    chk("add_t1_ain", 32'(bus.ain), 32'd1);
    edge_drive();
    @(negedge clk);
    chk("add_t2_rout", 32'(bus.rout), 32'h40);
    chk("add_t2_gin", 32'(bus.gin), 32'd1);
    chk("add_t2_addsub", 32'(bus.addsub), 32'd0);
    edge_drive();
    @(negedge clk);
    chk("add_t3_gout", 32'(bus.gout), 32'd1);
    chk("add_t3_rin", 32'(bus.rin), 32'h08);
    chk("add_t3_done", 32'(bus.done), 32'd1);
    edge_drive();
    @(negedge clk); chk("b2b_t0_tstep", 32'(bus.tstep), 32'd0);
    edge_drive();   bus.run = 1'b0;
    @(negedge clk); chk("sub_t1_tstep", 32'(bus.tstep), 32'd1);
    edge_drive();
    @(negedge clk);
    chk("sub_t2_rout", 32'(bus.rout), 32'h80);
    chk("sub_t2_addsub", 32'(bus.addsub), 32'd1);
    edge_drive();
    @(negedge clk);
    chk("sub_t3_rin", 32'(bus.rin), 32'h01);
    chk("sub_t3_done", 32'(bus.done), 32'd1);

    // reset during T2 of an add
    edge_drive();   bus.din = 16'h009E; bus.run = 1'b1;
    edge_drive();   bus.run = 1'b0;
    edge_drive();
    @(negedge clk); chk("abort_pre_gin", 32'(bus.gin), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tstep", 32'(bus.tstep), 32'd0);
    chk("abort_gin", 32'(bus.gin), 32'd0);
    chk("abort_rout", 32'(bus.rout), 32'h00);
    chk("abort_done", 32'(bus.done), 32'd0);
    edge_drive();   rst_n = 1'b1;
    edge_drive();
    @(negedge clk);
    chk("idle_tstep", 32'(bus.tstep), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // opcode 100 with Gnz high then low
    for (int g = 1; g >= 0; g--) begin
      edge_drive();   bus.din = 16'h0121; bus.run = 1'b1; bus.gnz = 1'(g);
      edge_drive();   bus.run = 1'b0;
      @(negedge clk);
      chk("op4_done", 32'(bus.done), 32'd1);
      chk("op4_rout", 32'(bus.rout), (MVNZ && g == 1) ? 32'h02 : 32'h00);
      chk("op4_rin", 32'(bus.rin), (MVNZ && g == 1) ? 32'h10 : 32'h00);
    end

    // randomized traffic with occasional resets; the per-cycle compare does the checking
    for (int i = 0; i < 3000; i++) begin
      edge_drive();
      bus.run = ($urandom_range(0, 3) != 0);
      bus.din = 16'($urandom);
      bus.gnz = 1'($urandom);
      rst_n   = ($urandom_range(0, 99) != 0);
    end
    edge_drive();
    rst_n = 1'b1;
    repeat (4) edge_drive();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
